// File: rtl/soc_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_fifo_pkg
//  Description : Shared types and helpers for the round-robin FIFO write
//                scheduler (scheduler states, ID width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_fifo_pkg;

   // Scheduler states: free arbitration, or locked to one packet owner
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } sched_st_t;

   // Width of a producer index; a single producer still gets one bit
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_write_sched_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first active
//                request found scanning upward (with wrap) from ptr_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import soc_fifo_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             valid_o
);

   int              j;
   logic [ID_W-1:0] w_j;

   // Scan from the priority pointer and keep only the first hit
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      w_j     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         w_j = ID_W'(j);
         if (!valid_o && req_i[w_j]) begin
            valid_o      = 1'b1;
            grant_o[w_j] = 1'b1;
            idx_o        = w_j;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_write_sched_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_gp_fifo
//  Description : Single-clock general-purpose FIFO with occupancy count,
//                synchronous flush and an overflow/underflow error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_gp_fifo #(
   parameter int WIDTH  = 8,
   parameter int SLOTS  = 8,
   parameter int OCUP_W = $clog2(SLOTS) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [OCUP_W-1:0] ocup_o,
   output logic              error_o
);

   localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   logic [WIDTH-1:0]  mem_q [SLOTS];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [OCUP_W-1:0] cnt_q, cnt_d;
   logic              w_wr_en, w_rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(SLOTS - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == OCUP_W'(SLOTS));
   assign empty_o = (cnt_q == '0);
   assign ocup_o  = cnt_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign w_wr_en = push_i & ~full_o & ~clear_i;
   assign w_rd_en = pop_i & ~empty_o & ~clear_i;
   assign error_o = ~clear_i & ((push_i & full_o) | (pop_i & empty_o));

   // Pointer and count next-state; flush wins over any push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (w_wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (w_rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (w_wr_en && !w_rd_en)      cnt_d = cnt_q + OCUP_W'(1);
         else if (!w_wr_en && w_rd_en) cnt_d = cnt_q - OCUP_W'(1);
      end
   end

   // Pointers clear synchronously while reset is held
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array, data only, no reset needed
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_write_sched
//  Description : Round-robin write scheduler sharing one FIFO between N_REQ
//                valid/ready producers. Packets hold the grant until last.
//                Each stored beat carries its source index.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_write_sched
   import soc_fifo_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 32,
   parameter int SLOTS     = 8,
   parameter int AF_THRESH = 2,
   parameter int ID_W      = id_w(N_REQ),
   parameter int OCUP_W    = $clog2(SLOTS) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear_i,
   input  logic [N_REQ-1:0]            req_valid_i,
   input  logic [N_REQ-1:0]            req_last_i,
   input  logic [N_REQ-1:0][WIDTH-1:0] req_data_i,
   output logic [N_REQ-1:0]            req_ready_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [WIDTH-1:0]            out_data_o,
   output logic [ID_W-1:0]             out_id_o,
   output logic                        out_last_o,
   output logic [OCUP_W-1:0]           ocup_o,
   output logic                        almost_full_o
);

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic             last;
      logic [WIDTH-1:0] data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   sched_st_t         state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   owner_q, owner_d;

   logic [N_REQ-1:0]  w_arb_grant;
   logic [ID_W-1:0]   w_arb_idx;
   logic              w_arb_valid;
   logic [N_REQ-1:0]  w_grant;
   logic [ID_W-1:0]   w_sel;
   logic              w_sel_valid;
   logic              w_can_push;
   logic              w_accept;
   logic              w_pop;
   entry_t            w_wr_entry;
   entry_t            w_head;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic              w_fifo_err;
   logic [OCUP_W-1:0] w_fifo_ocup;
   logic [OCUP_W-1:0] w_free;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .grant_o (w_arb_grant),
      .idx_o   (w_arb_idx),
      .valid_o (w_arb_valid)
   );

   // Grant source: arbiter when idle, packet owner only while locked
   always_comb begin
      w_grant     = '0;
      w_sel       = w_arb_idx;
      w_sel_valid = w_arb_valid;
      if (state_q == LOCK) begin
         w_grant[owner_q] = req_valid_i[owner_q];
         w_sel            = owner_q;
         w_sel_valid      = req_valid_i[owner_q];
      end else begin
         w_grant = w_arb_grant;
      end
   end

   // No write-through on pop: a full FIFO refuses every producer
   assign w_can_push = ~w_fifo_full & ~clear_i & ~rst;
   assign req_ready_o = w_grant & {N_REQ{w_can_push}};
   assign w_accept    = w_sel_valid & w_can_push;

   assign w_wr_entry.id   = w_sel;
   assign w_wr_entry.last = req_last_i[w_sel];
   assign w_wr_entry.data = req_data_i[w_sel];

   // Scheduler next state: clear abandons any packet, last releases the lock
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      if (clear_i) begin
         state_d  = IDLE;
         rr_ptr_d = '0;
      end else if (w_accept) begin
         if (w_wr_entry.last) begin
            state_d  = IDLE;
            rr_ptr_d = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + ID_W'(1);
         end else begin
            state_d = LOCK;
            owner_d = w_sel;
         end
      end
   end

   // Scheduler state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   sync_gp_fifo #(
      .WIDTH  (ENTRY_W),
      .SLOTS  (SLOTS),
      .OCUP_W (OCUP_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .push_i  (w_accept),
      .data_i  (w_wr_entry),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .ocup_o  (w_fifo_ocup),
      .error_o (w_fifo_err)
   );

   // Outputs read zero while empty or in reset
   assign out_valid_o   = ~w_fifo_empty & ~rst;
   assign w_pop         = out_valid_o & out_ready_i & ~clear_i;
   assign out_data_o    = out_valid_o ? w_head.data : '0;
   assign out_id_o      = out_valid_o ? w_head.id   : '0;
   assign out_last_o    = out_valid_o & w_head.last;
   assign ocup_o        = rst ? '0 : w_fifo_ocup;
   assign w_free        = OCUP_W'(SLOTS) - w_fifo_ocup;
   assign almost_full_o = ~rst & (int'(w_free) <= AF_THRESH);

   // The push/pop gating above must keep the FIFO from over/underflowing
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!w_fifo_err);
      end
   end

endmodule
`default_nettype wire
